// File: rtl/cfg_pkg.sv
// Shared encodings for the tile configuration loader.
package cfg_pkg;

  localparam int CFG_W = 8;

  // Byte position within one tile's four-byte configuration record.
  typedef enum logic [1:0] {
    FIELD_X  = 2'd0,
    FIELD_Y  = 2'd1,
    FIELD_AB = 2'd2,
    FIELD_CX = 2'd3
  } field_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_LOAD = 1'b1
  } state_e;

endpackage

// File: rtl/cfg_strobe_decode.sv
// Turns (tile index, field) into four one-hot per-tile write strobes.
// Purely combinational; the loader registers the outputs.
module cfg_strobe_decode
  import cfg_pkg::*;
#(
  parameter  int BLOCKS = 16,
  localparam int AW     = $clog2(BLOCKS)
) (
  input  logic              en,
  input  logic [AW-1:0]     tile,
  input  field_e            field,
  output logic [BLOCKS-1:0] dec_x,
  output logic [BLOCKS-1:0] dec_y,
  output logic [BLOCKS-1:0] dec_ab,
  output logic [BLOCKS-1:0] dec_cx
);

  // Only indices below BLOCKS exist, so an out-of-range tile value decodes to nothing.
  always_comb begin
    dec_x  = '0;
    dec_y  = '0;
    dec_ab = '0;
    dec_cx = '0;
    for (int i = 0; i < BLOCKS; i++) begin
      if (en && (tile == AW'(i))) begin
        case (field)
          FIELD_X:  dec_x[i]  = 1'b1;
          FIELD_Y:  dec_y[i]  = 1'b1;
          FIELD_AB: dec_ab[i] = 1'b1;
          FIELD_CX: dec_cx[i] = 1'b1;
          default:  ;
        endcase
      end
    end
  end

endmodule

// File: rtl/cfg_loader.sv
// Configuration sequencer: streams bytes into tiles 0..BLOCKS-1, four
// bytes per tile, driving a shared data bus plus per-tile write strobes.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   ST_IDLE | no load in progress; bytes refused; waits for start
//   ST_LOAD | accepting bytes; tile/field counters select the next target
module cfg_loader
  import cfg_pkg::*;
#(
  parameter  int BLOCKS = 16,
  localparam int AW     = $clog2(BLOCKS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [CFG_W-1:0]  in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [CFG_W-1:0]  cfg_out,
  output logic [BLOCKS-1:0] set_x,
  output logic [BLOCKS-1:0] set_y,
  output logic [BLOCKS-1:0] set_ab,
  output logic [BLOCKS-1:0] set_cx,
  output logic              busy,
  output logic              done
);

  localparam logic [AW-1:0] LAST_TILE = AW'(BLOCKS - 1);

  state_e        state_q, state_d;
  logic [AW-1:0] tile_q, tile_d;
  field_e        field_q, field_d;
  logic          done_q, done_d;
  logic          accept;

  logic [BLOCKS-1:0] dec_x, dec_y, dec_ab, dec_cx;

  // start owns the cycle it arrives in, so no byte can slip in alongside a restart.
  assign in_ready = (state_q == ST_LOAD) && !start;
  assign accept   = in_valid && in_ready;
  assign busy     = (state_q == ST_LOAD);
  assign done     = done_q;

  cfg_strobe_decode #(.BLOCKS(BLOCKS)) u_decode (
    .en    (accept),
    .tile  (tile_q),
    .field (field_q),
    .dec_x (dec_x),
    .dec_y (dec_y),
    .dec_ab(dec_ab),
    .dec_cx(dec_cx)
  );

  // Next-state, tile/field advance and the sticky done flag.
  always_comb begin
    state_d = state_q;
    tile_d  = tile_q;
    field_d = field_q;
    done_d  = done_q;
    if (start) begin
      state_d = ST_LOAD;
      tile_d  = '0;
      field_d = FIELD_X;
      done_d  = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: ;
        ST_LOAD: begin
          if (accept) begin
            if (field_q == FIELD_CX) begin
              field_d = FIELD_X;
              // The tile counter stops on the last tile rather than wrapping.
              if (tile_q == LAST_TILE) begin
                state_d = ST_IDLE;
                done_d  = 1'b1;
              end else begin
                tile_d = tile_q + AW'(1);
              end
            end else begin
              field_d = field_e'(field_q + 2'd1);
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // State/counter registers plus the registered bus and strobes.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      tile_q  <= '0;
      field_q <= FIELD_X;
      done_q  <= 1'b0;
      cfg_out <= '0;
      set_x   <= '0;
      set_y   <= '0;
      set_ab  <= '0;
      set_cx  <= '0;
    end else begin
      state_q <= state_d;
      tile_q  <= tile_d;
      field_q <= field_d;
      done_q  <= done_d;
      // Tiles ignore cfg_out without a strobe, so it simply holds between bytes.
      if (accept) cfg_out <= in_data;
      set_x  <= dec_x;
      set_y  <= dec_y;
      set_ab <= dec_ab;
      set_cx <= dec_cx;
    end
  end

endmodule

// File: tb/tb_cfg_loader.sv
// Bench for cfg_loader: a BLOCKS=2 and a BLOCKS=3 instance share stimulus
// and are each compared every cycle against a byte-count reference model.
module tb_cfg_loader;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       in_valid;
  logic [7:0] in_data;

  logic       rdy2, busy2, done2;
  logic [7:0] cfg2;
  logic [1:0] x2, y2, ab2, cx2;

  logic       rdy3, busy3, done3;
  logic [7:0] cfg3;
  logic [2:0] x3, y3, ab3, cx3;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state, index 0 = BLOCKS 2, index 1 = BLOCKS 3.
  bit         m_loading [2];
  bit         m_done    [2];
  int         m_k       [2];
  logic [7:0] m_cfg     [2];
  int         m_tile    [2];
  int         m_field   [2];
  bit         pre_exp   [2];
  logic       pre_obs   [2];

  logic [18:0] obs_b2, exp_b2;
  logic [22:0] obs_b3, exp_b3;

  cfg_loader #(.BLOCKS(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start), .in_data(in_data),
    .in_valid(in_valid), .in_ready(rdy2), .cfg_out(cfg2),
    .set_x(x2), .set_y(y2), .set_ab(ab2), .set_cx(cx2),
    .busy(busy2), .done(done2)
  );

  cfg_loader #(.BLOCKS(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(start), .in_data(in_data),
    .in_valid(in_valid), .in_ready(rdy3), .cfg_out(cfg3),
    .set_x(x3), .set_y(y3), .set_ab(ab3), .set_cx(cx3),
    .busy(busy3), .done(done3)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [2:0] strobe_vec(input int m, input int f);
    if (m_tile[m] >= 0 && m_field[m] == f) return 3'(1 << m_tile[m]);
    return 3'b000;
  endfunction

  // One clock: drive inputs, sample in_ready before the edge, advance the
  // model from byte counts, then sample outputs 1ns after the edge.
  task automatic tick(input bit s, input bit v, input logic [7:0] d, input bit r);
    logic [2:0] sx, sy, sa, sc;
    int nb;
    start = s; in_valid = v; in_data = d; rst_n = r;
    #1;
    pre_obs[0] = rdy2;
    pre_obs[1] = rdy3;
    for (int m = 0; m < 2; m++) pre_exp[m] = m_loading[m] && !s;
    @(posedge clk);
    for (int m = 0; m < 2; m++) begin
      nb = (m == 0) ? 2 : 3;
      if (!r) begin
        m_loading[m] = 0; m_done[m] = 0; m_k[m] = 0;
        m_cfg[m] = 8'h00; m_tile[m] = -1; m_field[m] = -1;
      end else begin
        if (v && pre_exp[m]) begin
          m_tile[m]  = m_k[m] / 4;
          m_field[m] = m_k[m] % 4;
          m_cfg[m]   = d;
        end else begin
          m_tile[m] = -1; m_field[m] = -1;
        end
        if (s) begin
          m_loading[m] = 1; m_k[m] = 0; m_done[m] = 0;
        end else if (v && pre_exp[m]) begin
          m_k[m]++;
          if (m_k[m] == 4 * nb) begin
            m_loading[m] = 0; m_done[m] = 1;
          end
        end
      end
    end
    #1;
    sx = strobe_vec(0, 0); sy = strobe_vec(0, 1); sa = strobe_vec(0, 2); sc = strobe_vec(0, 3);
    exp_b2 = {pre_exp[0], m_loading[0], m_done[0], m_cfg[0], sx[1:0], sy[1:0], sa[1:0], sc[1:0]};
    obs_b2 = {pre_obs[0], busy2, done2, cfg2, x2, y2, ab2, cx2};
    sx = strobe_vec(1, 0); sy = strobe_vec(1, 1); sa = strobe_vec(1, 2); sc = strobe_vec(1, 3);
    exp_b3 = {pre_exp[1], m_loading[1], m_done[1], m_cfg[1], sx, sy, sa, sc};
    obs_b3 = {pre_obs[1], busy3, done3, cfg3, x3, y3, ab3, cx3};
  endtask

  task automatic test_reset();
    tick(1'b1, 1'b1, 8'h5A, 1'b0);
    n_cmp++;
    if (obs_b2 !== exp_b2) begin n_bad++; $display("FAIL reset b2: got %h want %h", obs_b2, exp_b2); end
    n_cmp++;
    if (obs_b3 !== exp_b3) begin n_bad++; $display("FAIL reset b3: got %h want %h", obs_b3, exp_b3); end
    n_cmp++;
    if ({busy2, done2, cfg2, x2, y2, ab2, cx2} !== 18'h0) begin
      n_bad++; $display("FAIL reset_values b2: got %h want 0", {busy2, done2, cfg2, x2, y2, ab2, cx2});
    end
    tick(1'b0, 1'b1, 8'h5A, 1'b1);
    n_cmp++;
    if (pre_obs[0] !== 1'b0) begin n_bad++; $display("FAIL reset_ready b2: got %b want 0", pre_obs[0]); end
  endtask

  task automatic test_full_load();
    tick(1'b1, 1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 8; i++) begin
      tick(1'b0, 1'b1, 8'(8'h11 * (i + 1)), 1'b1);
      n_cmp++;
      if (obs_b2 !== exp_b2) begin n_bad++; $display("FAIL full_load b2 step %0d: got %h want %h", i, obs_b2, exp_b2); end
      n_cmp++;
      if (obs_b3 !== exp_b3) begin n_bad++; $display("FAIL full_load b3 step %0d: got %h want %h", i, obs_b3, exp_b3); end
      n_cmp++;
      if (cfg2 !== 8'(8'h11 * (i + 1))) begin n_bad++; $display("FAIL full_load_data step %0d: got %h want %h", i, cfg2, 8'(8'h11 * (i + 1))); end
    end
    n_cmp++;
    if ({cx2, done2, busy2} !== 4'b1010) begin
      n_bad++; $display("FAIL full_load_end b2: got cx/done/busy %b want 1010", {cx2, done2, busy2});
    end
  endtask

  task automatic test_gapped_load();
    int accepts = 0;
    tick(1'b1, 1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 16; i++) begin
      tick(1'b0, (i % 2) == 0, 8'(8'h11 * (accepts + 1)), 1'b1);
      if ((i % 2) == 0) accepts++;
      n_cmp++;
      if (obs_b2 !== exp_b2) begin n_bad++; $display("FAIL gapped b2 step %0d: got %h want %h", i, obs_b2, exp_b2); end
      n_cmp++;
      if (obs_b3 !== exp_b3) begin n_bad++; $display("FAIL gapped b3 step %0d: got %h want %h", i, obs_b3, exp_b3); end
      if ((i % 2) == 1) begin
        n_cmp++;
        if ({x2, y2, ab2, cx2} !== 8'h00) begin n_bad++; $display("FAIL gapped_quiet step %0d: got %h want 00", i, {x2, y2, ab2, cx2}); end
      end
    end
    n_cmp++;
    if (done2 !== 1'b1) begin n_bad++; $display("FAIL gapped_done b2: got %b want 1", done2); end
  endtask

  task automatic test_idle_ignore();
    for (int i = 0; i < 3; i++) begin
      tick(1'b0, 1'b1, 8'hAA, 1'b1);
      n_cmp++;
      if (obs_b2 !== exp_b2) begin n_bad++; $display("FAIL idle b2 step %0d: got %h want %h", i, obs_b2, exp_b2); end
      n_cmp++;
      if ({pre_obs[0], x2, y2, ab2, cx2, done2} !== 10'b0_00000000_1) begin
        n_bad++; $display("FAIL idle_quiet b2 step %0d: got %b want 0000000001", i, {pre_obs[0], x2, y2, ab2, cx2, done2});
      end
    end
  endtask

  task automatic test_restart();
    tick(1'b1, 1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 5; i++) tick(1'b0, 1'b1, 8'(8'h21 + i), 1'b1);
    n_cmp++;
    if (x2 !== 2'b10) begin n_bad++; $display("FAIL restart_fifth_strobe b2: got %b want 10", x2); end
    tick(1'b1, 1'b1, 8'hEE, 1'b1);
    n_cmp++;
    if (obs_b2 !== exp_b2) begin n_bad++; $display("FAIL restart_cycle b2: got %h want %h", obs_b2, exp_b2); end
    n_cmp++;
    if (obs_b3 !== exp_b3) begin n_bad++; $display("FAIL restart_cycle b3: got %h want %h", obs_b3, exp_b3); end
    n_cmp++;
    if ({pre_obs[0], cfg2} !== {1'b0, 8'h25}) begin n_bad++; $display("FAIL restart_no_accept b2: got %h want 025", {pre_obs[0], cfg2}); end
    tick(1'b0, 1'b1, 8'h31, 1'b1);
    n_cmp++;
    if ({x2, done2, cfg2} !== {2'b01, 1'b0, 8'h31}) begin
      n_bad++; $display("FAIL restart_first b2: got %h want %h", {x2, done2, cfg2}, {2'b01, 1'b0, 8'h31});
    end
    n_cmp++;
    if (obs_b3 !== exp_b3) begin n_bad++; $display("FAIL restart_first b3: got %h want %h", obs_b3, exp_b3); end
  endtask

  task automatic test_reset_midload();
    tick(1'b1, 1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b1, 8'(8'h41 + i), 1'b1);
    tick(1'b0, 1'b1, 8'h44, 1'b0);
    n_cmp++;
    if ({busy2, done2, cfg2, x2, y2, ab2, cx2} !== 18'h0) begin
      n_bad++; $display("FAIL midreset b2: got %h want 0", {busy2, done2, cfg2, x2, y2, ab2, cx2});
    end
    n_cmp++;
    if (obs_b3 !== exp_b3) begin n_bad++; $display("FAIL midreset b3: got %h want %h", obs_b3, exp_b3); end
    tick(1'b0, 1'b1, 8'h45, 1'b1);
    n_cmp++;
    if ({pre_obs[0], x2, y2, ab2, cx2} !== 9'h0) begin
      n_bad++; $display("FAIL midreset_quiet b2: got %h want 0", {pre_obs[0], x2, y2, ab2, cx2});
    end
    tick(1'b1, 1'b0, 8'h00, 1'b1);
    tick(1'b0, 1'b1, 8'h46, 1'b1);
    n_cmp++;
    if (obs_b2 !== exp_b2) begin n_bad++; $display("FAIL midreset_reload b2: got %h want %h", obs_b2, exp_b2); end
    n_cmp++;
    if (x3 !== 3'b001) begin n_bad++; $display("FAIL midreset_reload b3: got %b want 001", x3); end
  endtask

  task automatic test_blocks3_full();
    int busy_cycles = 0;
    tick(1'b1, 1'b0, 8'h00, 1'b1);
    if (busy3 === 1'b1) busy_cycles++;
    for (int i = 0; i < 12; i++) begin
      tick(1'b0, 1'b1, 8'(8'h80 + i), 1'b1);
      if (busy3 === 1'b1) busy_cycles++;
      n_cmp++;
      if (obs_b3 !== exp_b3) begin n_bad++; $display("FAIL b3_load step %0d: got %h want %h", i, obs_b3, exp_b3); end
      n_cmp++;
      if (obs_b2 !== exp_b2) begin n_bad++; $display("FAIL b3_load b2 step %0d: got %h want %h", i, obs_b2, exp_b2); end
    end
    n_cmp++;
    if ({cx3, done3, busy3} !== 5'b100_1_0) begin
      n_bad++; $display("FAIL b3_final: got cx/done/busy %b want 10010", {cx3, done3, busy3});
    end
    n_cmp++;
    if (busy_cycles != 12) begin n_bad++; $display("FAIL b3_busy_cycles: got %0d want 12", busy_cycles); end
    tick(1'b0, 1'b1, 8'hFF, 1'b1);
    n_cmp++;
    if ({pre_obs[1], x3, y3, ab3, cx3} !== 13'h0) begin
      n_bad++; $display("FAIL b3_thirteenth: got %h want 0", {pre_obs[1], x3, y3, ab3, cx3});
    end
  endtask

  task automatic test_random();
    bit s, v, r;
    for (int i = 0; i < 600; i++) begin
      s = ($urandom_range(0, 19) == 0);
      v = ($urandom_range(0, 9) < 7);
      r = ($urandom_range(0, 99) != 0);
      tick(s, v, 8'($urandom), r);
      n_cmp++;
      if (obs_b2 !== exp_b2) begin n_bad++; $display("FAIL random b2 cyc %0d: got %h want %h", i, obs_b2, exp_b2); end
      n_cmp++;
      if (obs_b3 !== exp_b3) begin n_bad++; $display("FAIL random b3 cyc %0d: got %h want %h", i, obs_b3, exp_b3); end
      n_cmp++;
      if ($countones({x3, y3, ab3, cx3}) > 1) begin
        n_bad++; $display("FAIL random_onehot b3 cyc %0d: got %b want at most one bit", i, {x3, y3, ab3, cx3});
      end
    end
  endtask

  initial begin
    start = 1'b0; in_valid = 1'b0; in_data = 8'h00; rst_n = 1'b0;
    for (int m = 0; m < 2; m++) begin
      m_loading[m] = 0; m_done[m] = 0; m_k[m] = 0;
      m_cfg[m] = 8'h00; m_tile[m] = -1; m_field[m] = -1;
    end
    tick(1'b0, 1'b0, 8'h00, 1'b0);
    tick(1'b0, 1'b0, 8'h00, 1'b0);
    test_reset();
    test_full_load();
    test_idle_ignore();
    test_gapped_load();
    test_restart();
    test_reset_midload();
    test_blocks3_full();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/cfg_loader.md
# cfg_loader

Configuration sequencer for the tile array: accepts a byte stream over a valid/ready handshake and writes it into the per-tile configuration registers. Drives the shared `cfg_in` bus and one-hot `set_x`/`set_y`/`set_ab`/`set_cx` strobes. Loads tiles 0..BLOCKS-1 in order, four bytes per tile (x LUT, y LUT, ab select, cx select/async). Sits between the chip I/O byte port and the tile grid.

## Interface
- BLOCKS, default 16: number of tiles. Legal range is 2..256.
- AW, default $clog2(BLOCKS): tile index width. Derived; not overridden.
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- start  in  1  one-cycle request to begin (or restart) a load at tile 0
- in_data  in  8  configuration byte
- in_valid  in  1  in_data valid
- in_ready  out  1  byte accepted this cycle when in_valid && in_ready
- cfg_out  out  8  to every tile's cfg_in; registered
- set_x  out  BLOCKS  per-tile x-LUT write strobe; registered, at most one bit set
- set_y  out  BLOCKS  per-tile y-LUT write strobe
- set_ab  out  BLOCKS  per-tile ab write strobe
- set_cx  out  BLOCKS  per-tile cx write strobe
- busy  out  1  high in LOAD state
- done  out  1  sticky: last byte of a load has been written

## Operation
- States are IDLE and LOAD.
- IDLE:
  - in_ready=0.
  - start → LOAD, tile=0, field=X, done←0.
- LOAD:
  - in_ready = !start.
  - On each accepted byte:
    - cfg_out←in_data.
    - Next cycle, exactly one strobe bit is high: set_<field>[tile].
    - Field then advances X→Y→AB→CX.
    - After CX, field wraps to X and tile increments.
- Last byte (tile=BLOCKS-1, field=CX) accepted → IDLE, done←1. No wrap of tile.
- start in LOAD:
  - Restarts at tile 0, field X, done←0.
  - No byte is accepted that cycle; in_ready is 0.
  - A strobe already registered from the previous cycle's byte still fires.
- start in the same cycle as the last byte: start has priority. The byte is not accepted; the load restarts.
- in_valid low in LOAD:
  - All strobes are 0; counters hold; cfg_out holds its last value.
- Strobe vectors and cfg_out are 0 whenever no byte was accepted in the previous cycle. Exception: cfg_out holds its last value, and this is permitted because tiles ignore it without a strobe.
- Field counter is 2 bits. Tile counter is AW bits and compares against BLOCKS-1, so non-power-of-2 BLOCKS never addresses a nonexistent tile.

## Timing
- Reset values: state IDLE, in_ready=0, cfg_out=8'h00, all strobes 0, busy=0, done=0.
- rst_n low mid-load: abort immediately; no strobe in the following cycle.
  - Tiles share rst_n and clear their own config.
- Latency: byte accepted at edge N → cfg_out and strobe valid in cycle N+1 → tile captures at edge N+2.
- Throughput: one byte per cycle. in_ready does not depend on strobe state.
- busy rises the cycle after start. It falls the cycle after the last byte is accepted, the same cycle as the final set_cx strobe.
- done rises in that same cycle and holds until start or reset.
- A full load takes 4·BLOCKS accepted bytes. With continuous in_valid, busy is high for exactly 4·BLOCKS cycles.

## Structure
- Package cfg_pkg holds:
  - Field encoding: FIELD_X=2'd0, FIELD_Y=2'd1, FIELD_AB=2'd2, FIELD_CX=2'd3.
  - State encoding: ST_IDLE, ST_LOAD.
  - CFG_W=8.
- Sub-module cfg_strobe_decode: combinational tile-index-plus-field to four one-hot BLOCKS-wide vectors, with an enable input. Its outputs are registered in cfg_loader.
- The FSM, counters and the cfg_out register live in cfg_loader.

## Test plan
- BLOCKS=2, start, then 8 consecutive bytes 0x11..0x88:
  - Strobes appear in order set_x[0], set_y[0], set_ab[0], set_cx[0], set_x[1] … set_cx[1].
  - cfg_out = 0x11..0x88, one per cycle.
  - done=1 with set_cx[1]; busy low on the same cycle.
  - Exactly one strobe bit high per cycle.
- Same load with in_valid low every other cycle: identical strobe/data sequence with gaps; all strobes 0 in gap cycles; done after 8 accepts.
- in_valid=1 with data 0xAA while IDLE: in_ready=0, no strobes, done unchanged.
- After 5 bytes, pulse start with in_valid=1:
  - The 5th strobe (set_x[1]) still fires.
  - No accept on the start cycle.
  - The next byte produces set_x[0].
  - done=0.
- rst_n low for 1 cycle after 3 bytes:
  - All outputs return to reset values the next cycle; no stray strobe.
  - A subsequent start loads from tile 0.
- BLOCKS=3, full 12-byte load: final strobe is set_cx[2]; tile index never reaches 3; a 13th offered byte sees in_ready=0.
